// File: rtl/serial_adder_seq.sv
// Bit-serial adder: loads two N-bit operands, adds them LSB first through one full_adder cell
// with the carry held in a flop, then presents the registered sum and carry with a done pulse.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN (adds input port sub).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_seq #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum_out,
  output logic         cout_out
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    result_q;
  logic            carry_q;
  logic [CntW-1:0] count_q;

  logic [N-1:0]    b_load;
  logic            carry_load;
  logic            fa_sum;
  logic            fa_cout;
  logic [N-1:0]    result_next;

  // The zero-initialised LSB of result is shifted out on the last edge and never observed.
  logic            unused_result_lsb;
  assign unused_result_lsb = result_q[0];

  // Subtract is a + ~b + 1; cin_in plays no part in that case.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b_in : b_in;
    carry_load = sub ? 1'b1 : cin_in;
`else
    b_load     = b_in;
    carry_load = cin_in;
`endif
  end

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign result_next = {fa_sum, result_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_load;
            carry_q  <= carry_load;
            count_q  <= '0;
            result_q <= '0;
            busy     <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= fa_cout;
          result_q <= result_next;
          count_q  <= count_q + 1'b1;
          if (count_q == LastBit) begin
            sum_out  <= result_next;
            cout_out <= fa_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq (N=4): vector table plus hand-written sequences, results checked
// against a scoreboard queue popped on every done pulse.

module tb_serial_adder_seq;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         cin_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum_out;
  logic         cout_out;

  serial_adder_seq #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         c;
  } vec_t;

  logic [N:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        logic [N:0] e;
        e = sb_q.pop_front();
        check("sum_out", sum_out, e[N-1:0]);
        check("cout_out", cout_out, e[N]);
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check(name, seen, 1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sb, input logic [N:0] exp, input bit scramble);
    int  nb;
    bit  seen;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = sb;
`else
    if (sb) $display("note: sub request ignored in add-only build");
`endif
    start  = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    nb   = 0;
    seen = 0;
    for (int i = 0; i < 3 * N && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        if (busy === 1'b1) nb++;
        if (scramble) begin
          a_in   = N'($urandom);
          b_in   = N'($urandom);
          cin_in = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    check("busy_cycles", nb, N);
    check("done_busy_low", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   t1;
    int   t2;

    vecs[0] = '{a: 4'd5,  b: 4'd3,  cin: 1'b0, s: 4'd8,  c: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, s: 4'd0,  c: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, c: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  cin: 1'b1, s: 4'd1,  c: 1'b0};
    vecs[4] = '{a: 4'd10, b: 4'd5,  cin: 1'b0, s: 4'd15, c: 1'b0};
    vecs[5] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, s: 4'd0,  c: 1'b1};
    vecs[6] = '{a: 4'd7,  b: 4'd9,  cin: 1'b1, s: 4'd1,  c: 1'b1};

    reset  = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum_out, 0);
    check("reset_cout", cout_out, 0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, {vecs[i].c, vecs[i].s}, 0);

    // start held high: 2+2 then 7+9, second accepted only after DONE/IDLE
    @(negedge clk);
    a_in   = 4'd2;
    b_in   = 4'd2;
    cin_in = 1'b0;
    start  = 1'b1;
    sb_q.push_back({1'b0, 4'd4});
    @(negedge clk);
    check("held_accept1", busy, 1);
    a_in = 4'd7;
    b_in = 4'd9;
    sb_q.push_back({1'b1, 4'd0});
    wait_done("held_done1", 4 * N);
    t1 = cyc;
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    @(negedge clk);
    check("held_accept2", busy, 1);
    start = 1'b0;
    wait_done("held_done2", 4 * N);
    t2 = cyc;
    check("held_gap", t2 - t1, N + 2);
    @(negedge clk);

    // reset during third SHIFT cycle of 6+6 aborts with no partial result
    @(negedge clk);
    a_in  = 4'd6;
    b_in  = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_shift", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum_out, 0);
    check("abort_cout", cout_out, 0);
    repeat (2 * N) @(negedge clk);
    run_op(4'd1, 4'd1, 1'b0, 1'b0, {1'b0, 4'd2}, 0);

    // operands changing after acceptance must not disturb the result
    run_op(4'd9, 4'd4, 1'b0, 1'b0, {1'b0, 4'd13}, 1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(4'd3, 4'd5, 1'b0, 1'b1, {1'b0, 4'd14}, 0);
    run_op(4'd9, 4'd4, 1'b0, 1'b1, {1'b1, 4'd5}, 0);
    run_op(4'd3, 4'd5, 1'b1, 1'b1, {1'b0, 4'd14}, 0);
    run_op(4'd9, 4'd4, 1'b1, 1'b0, {1'b0, 4'd14}, 0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
